// File: rtl/md_scheduler.sv
// md_scheduler: sequencing controller for the E-stage multiply/divide unit.
// Issues mult/div ops, counts out their latency, owns HI/LO and raises the
// D-stage stall while an op is being issued or is in flight.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        op_valid_i,
    input  logic [2:0]  md_op_i,
    input  logic [31:0] d1_i,
    input  logic [31:0] d2_i,
    input  logic        d_is_md_i,
    output logic        start_o,
    output logic        busy_o,
    output logic        stall_md_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              done_q, done_d;

    logic              is_muldiv;
    logic [63:0]       prod_s, prod_u;
    logic [31:0]       div_b;
    logic [31:0]       quo_s, rem_s, quo_u, rem_u;

    // Ops 001..100 occupy the unit; mthi/mtlo are single-edge register writes.
    assign is_muldiv = (md_op_i == OP_MULT) || (md_op_i == OP_MULTU) ||
                       (md_op_i == OP_DIV)  || (md_op_i == OP_DIVU);

    assign start_o    = op_valid_i & is_muldiv & (state_q == IDLE);
    assign busy_o     = (state_q == RUN);
    assign stall_md_o = d_is_md_i & (start_o | busy_o);
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    // Results from the captured operands; a zero divisor is replaced by 1 so
    // the divider never produces X (the result is discarded in that case).
    always_comb begin
        prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
        quo_s  = 32'($signed(a_q) / $signed(div_b));
        rem_s  = 32'($signed(a_q) % $signed(div_b));
        quo_u  = a_q / div_b;
        rem_u  = a_q % div_b;
    end

    // Next-state logic: issue, latency countdown, result writeback, mthi/mtlo.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_o) begin
                    op_d    = md_op_i;
                    a_d     = d1_i;
                    b_d     = d2_i;
                    cnt_d   = ((md_op_i == OP_MULT) || (md_op_i == OP_MULTU)) ?
                              CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d = RUN;
                end else if (op_valid_i && (md_op_i == OP_MTHI)) begin
                    hi_d = d1_i;
                end else if (op_valid_i && (md_op_i == OP_MTLO)) begin
                    lo_d = d1_i;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (b_q != 32'd0) begin
                                lo_d = quo_s;
                                hi_d = rem_s;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                lo_d = quo_u;
                                hi_d = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and architectural registers; reset aborts any op in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed vectors for md_scheduler with hand-computed results.
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] d1, d2;
    logic        d_is_md;
    logic        start, busy, stall_md, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .op_valid_i (op_valid),
        .md_op_i    (md_op),
        .d1_i       (d1),
        .d2_i       (d2),
        .d_is_md_i  (d_is_md),
        .start_o    (start),
        .busy_o     (busy),
        .stall_md_o (stall_md),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue in the current cycle, walk the busy cycles, end in cycle N+1.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic dmd,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        op_valid = 1'b1; md_op = op; d1 = a; d2 = b; d_is_md = dmd;
        #1;
        chk({name, " start c0"}, 32'(start), 32'd1);
        chk({name, " stall c0"}, 32'(stall_md), 32'(dmd));
        step();
        op_valid = 1'b0; md_op = 3'b000; d1 = 32'hDEAD_BEEF; d2 = 32'h0BAD_F00D;
        for (int c = 1; c <= n; c++) begin
            #1;
            chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'd1);
            chk($sformatf("%s stall c%0d", name, c), 32'(stall_md), 32'(dmd));
            chk($sformatf("%s done c%0d", name, c), 32'(done), 32'd0);
            step();
        end
        #1;
        chk({name, " busy end"}, 32'(busy), 32'd0);
        chk({name, " done end"}, 32'(done), 32'd1);
        chk({name, " stall end"}, 32'(stall_md), 32'd0);
        chk({name, " hi"}, hi, exp_hi);
        chk({name, " lo"}, lo, exp_lo);
        $display("txn %s a=0x%08h b=0x%08h hi=0x%08h lo=0x%08h", name, a, b, hi, lo);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; md_op = 3'b000; d1 = '0; d2 = '0; d_is_md = 1'b0;
        step();
        step();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        $display("txn reset hi=0x%08h lo=0x%08h", hi, lo);
        rst = 1'b0;
        step();

        // mult with stall held, then back-to-back multu with no stall request.
        run_op("mult",  3'b001, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'b011, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'b100, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'h0000_0001, 32'h7FFF_FFFC);

        // mthi: no start, no busy, no done.
        op_valid = 1'b1; md_op = 3'b101; d1 = 32'h1234_5678; d_is_md = 1'b1;
        #1;
        chk("mthi start", 32'(start), 32'd0);
        chk("mthi stall", 32'(stall_md), 32'd0);
        step();
        op_valid = 1'b0; md_op = 3'b000;
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi busy", 32'(busy), 32'd0);
        chk("mthi done", 32'(done), 32'd0);
        $display("txn mthi hi=0x%08h lo=0x%08h", hi, lo);

        // Divide by zero leaves HI/LO untouched but still runs and pulses done.
        run_op("div0", 3'b011, 32'd5, 32'd0, 10, 1'b0, 32'h1234_5678, 32'h7FFF_FFFC);
        step();
        chk("div0 done drop", 32'(done), 32'd0);

        // Reset in busy cycle 3 of a div aborts it.
        op_valid = 1'b1; md_op = 3'b011; d1 = 32'd100; d2 = 32'd7;
        step();
        op_valid = 1'b0; md_op = 3'b000;
        step();
        step();
        chk("abort busy c3", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("abort nodone %0d", c), 32'(done), 32'd0);
            chk($sformatf("abort idle %0d", c), 32'(busy), 32'd0);
        end
        $display("txn abort hi=0x%08h lo=0x%08h", hi, lo);

        // mtlo after the abort.
        op_valid = 1'b1; md_op = 3'b110; d1 = 32'hA5A5_A5A5;
        #1;
        chk("mtlo start", 32'(start), 32'd0);
        step();
        op_valid = 1'b0; md_op = 3'b000;
        chk("mtlo lo", lo, 32'hA5A5_A5A5);
        chk("mtlo hi", hi, 32'd0);
        $display("txn mtlo hi=0x%08h lo=0x%08h", hi, lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
